// File: rtl/data_ram_resp_if.sv
// ============================================================================
// Module : data_ram_resp_if -- MEM-stage load/store port bundle. Rev 1.0
// ============================================================================
`default_nettype none

interface data_ram_resp_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        mem_err_o;
  logic        stallreq_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, mem_err_o, stallreq_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, mem_err_o, stallreq_o
  );
endinterface

`default_nettype wire

// File: rtl/data_ram_resp.sv
// ============================================================================
// Module : data_ram_resp -- data RAM responder with fixed wait states. Rev 1.0
// ============================================================================
`default_nettype none

module data_ram_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  data_ram_resp_if.slave bus
);

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [3:0]              sel_q;
  logic [31:0]             wdata_q;
  logic                    oor_q;
  logic [31:0]             rdata_q;
  logic                    err_q;
  logic [31:0]             ram_q [DEPTH];

  logic                    accept;
  logic                    commit;
  logic                    oor_in;
  logic                    we_c;
  logic [ADDR_WIDTH-1:0]   idx_c;
  logic [3:0]              sel_c;
  logic [31:0]             wdata_c;
  logic                    oor_c;
  logic                    unused_addr_lsb;

  assign oor_in          = |bus.mem_addr_i[31:ADDR_WIDTH+2];
  assign unused_addr_lsb = ^bus.mem_addr_i[1:0];

  // With zero wait states the commit edge is the accept edge, so use live inputs.
  assign we_c    = (state_q == S_IDLE) ? bus.mem_we_i                      : we_q;
  assign idx_c   = (state_q == S_IDLE) ? bus.mem_addr_i[ADDR_WIDTH+1:2]    : idx_q;
  assign sel_c   = (state_q == S_IDLE) ? bus.mem_sel_i                     : sel_q;
  assign wdata_c = (state_q == S_IDLE) ? bus.mem_data_i                    : wdata_q;
  assign oor_c   = (state_q == S_IDLE) ? oor_in                            : oor_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_ce_i) begin
          accept = 1'b1;
          cnt_d  = C_WAIT;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
            commit  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      oor_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.mem_we_i;
        idx_q   <= bus.mem_addr_i[ADDR_WIDTH+1:2];
        sel_q   <= bus.mem_sel_i;
        wdata_q <= bus.mem_data_i;
        oor_q   <= oor_in;
      end
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      if (commit) begin
        err_q   <= oor_c;
        rdata_q <= oor_c ? 32'd0 : ram_q[idx_c];
      end
    end
  end

  // RAM contents survive reset; only a committing, in-range write touches them.
  always_ff @(posedge clk) begin
    if (!rst && commit && we_c && !oor_c) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_c[b]) begin
          ram_q[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_ack_o  = (state_q == S_RESP);
  assign bus.mem_err_o  = err_q;
  assign bus.mem_data_o = rdata_q;
  assign bus.stallreq_o = bus.mem_ce_i & ~bus.mem_ack_o;

endmodule

`default_nettype wire
